// File: rtl/div_sequencer.sv
// Iterative RV32M divide sequencer (DIV/DIVU/REM/REMU): radix-2 restoring division
// with RISC-V special-case handling, sign fixup and tagged valid/ready result.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] result_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic               sel_rem_q, sel_rem_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN:0]      rem_q, rem_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    dvsr_q, dvsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               is_signed;
    logic               ovf;
    logic [XLEN-1:0]    dvnd_abs;
    logic [XLEN-1:0]    dvsr_abs;
    logic [XLEN+1:0]    shifted;
    logic [XLEN+1:0]    trial;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;

    assign is_signed = ~op[0];
    assign ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor);
    assign dvnd_abs  = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
    assign dvsr_abs  = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

    // Extra guard bit on the shifted partial remainder makes the trial sign a plain MSB test.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {2'b00, dvsr_q};

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        // NOTE: every _d takes its held value first so no path through the case infers a latch.
        state_d   = state_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        tag_d     = tag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid && !flush) begin
                    sel_rem_d = op[1];
                    tag_d     = tag_in;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = dvnd_abs;
                        dvsr_d    = dvsr_abs;
                        neg_quo_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_rem_d = is_signed && dividend[XLEN-1];
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[XLEN+1]) begin
                    rem_d = trial[XLEN:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = sel_rem_q ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            tag_q     <= tag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_tag   = tag_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative sequencer for the RV32M divide group (DIV, DIVU, REM, REMU) in the execute stage. It accepts one operation via a valid/ready handshake and runs a radix-2 restoring division over XLEN cycles, applying the RISC-V special-case rules and sign fixup. It returns the result with a destination tag via a second valid/ready handshake. `busy` drives the pipeline hazard/stall logic.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 5, destination register tag width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_valid  in  1  operation offered
- start_ready  out  1  high exactly when state is IDLE
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  XLEN  rs1 value
- divisor  in  XLEN  rs2 value
- tag_in  in  TAG_W  rd index
- flush  in  1  synchronous kill of the in-flight operation
- result_valid  out  1  high exactly when state is DONE
- result_ready  in  1  consumer accepts result
- result  out  XLEN  quotient or remainder
- result_tag  out  TAG_W  tag_in captured at accept
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: on start_valid && start_ready && !flush, capture op, tag and operands, then:
    - divisor == 0 → DONE;
    - op==DIV/REM with dividend == 0x80000000 and divisor == 0xFFFFFFFF → DONE;
    - otherwise → CALC.
  - CALC: XLEN iterations, then → FIX.
  - FIX: sign fixup and result select, then → DONE.
  - DONE: hold until result_ready, then → IDLE.
- Signed ops (op[0]==0):
  - Operate on absolute values.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Unsigned ops: use operands directly.
- Datapath:
  - Partial remainder register is XLEN+1 bits.
  - Each iteration shifts {rem, quo} left by 1, trial-subtracts |divisor|, and on a non-negative result keeps the difference and sets quo[0]=1.
- Iteration counter: $clog2(XLEN) bits, cleared at accept, increments in CALC; CALC exits when count == XLEN-1.
- Divide by zero:
  - quotient = all ones;
  - remainder = dividend (unmodified, signed or not).
- Signed overflow: quotient = 0x80000000, remainder = 0.
- result is the quotient for op[1]==0 and the remainder for op[1]==1.
- result and result_tag are registered and stable throughout DONE.
- flush:
  - From any state, the next edge goes to IDLE.
  - result_valid drops and no result is delivered.
  - flush blocks acceptance in the same cycle.
  - flush in the same cycle as a DONE handshake counts as a flush; the consumer must ignore it.
- No accept in the cycle that completes the DONE handshake; the next accept is possible one cycle later.

## Timing
- Reset (rst_n low, async), all registers cleared:
  - state=IDLE;
  - result_valid=0, result=0, result_tag=0, busy=0;
  - start_ready=1 once rst_n is released.
- Normal latency:
  - Accept edge t0.
  - CALC edges t1..tXLEN.
  - FIX edge tXLEN+1.
  - result_valid high from after edge t0+XLEN+1 (33 edges for XLEN=32).
- Special-case latency: result_valid high after the accept edge t0 (1 cycle).
- busy is high from the cycle after accept until the cycle after the DONE handshake or flush.
- Backpressure: DONE is held indefinitely; result and result_tag do not change.
- rst_n asserted mid-CALC: immediately IDLE, all outputs at reset values; no residual result after release.

## Test plan
- DIV 100 / 7, tag 3:
  - result 14, result_tag 3;
  - result_valid on the 33rd edge after accept;
  - busy high for the whole operation.
- REM -100 (0xFFFFFF9C) / 7 → 0xFFFFFFFE.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- REMU 0xFFFFFFFF / 2 → 1.
- Divide by zero, each with result_valid 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - REMU 0x80000000/0 → 0x80000000.
- Overflow, each in 1 cycle:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- Control events:
  - result_ready low for 5 cycles in DONE: result stable, start_ready 0.
  - flush at CALC cycle 10: IDLE next edge, no result_valid pulse, new op accepted next cycle.
  - rst_n low at CALC cycle 20: outputs zero immediately, no result after release.
